intr_claim_ctrl: RTL and testbench

Interrupt claim controller for the Sunburst top level. It sits on the consuming end of the peripheral interrupt vectors (AON timer, I2C, SPI host, UART, USB device), concatenated into one flat source bus. It latches each source through a gateway, masks it with per-source enables, and drives a single level interrupt to the CPU. Software claims the winning source and later completes it through a small register port.

---
 rtl/intr_claim_ctrl_pkg.sv | 31 +++
 rtl/intr_claim_gateway.sv | 31 +++
 rtl/intr_claim_ctrl.sv | 122 ++++++++++++
 tb/tb_intr_claim_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/intr_claim_ctrl_pkg.sv
// Shared constants and types for the interrupt claim controller.
// Holds source count, ID width, register offsets and the register request payload.
package intr_claim_ctrl_pkg;

    localparam int unsigned NumIrqSrc    = 46;
    localparam int unsigned IrqIdWidth   = 7;
    localparam int unsigned RegAddrWidth = 3;
    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned MaxSrc       = 64;

    localparam logic [RegAddrWidth-1:0] IntrEnable0Offset  = 3'd0;
    localparam logic [RegAddrWidth-1:0] IntrEnable1Offset  = 3'd1;
    localparam logic [RegAddrWidth-1:0] IntrPending0Offset = 3'd2;
    localparam logic [RegAddrWidth-1:0] IntrPending1Offset = 3'd3;
    localparam logic [RegAddrWidth-1:0] IntrClaimOffset    = 3'd4;

    typedef struct packed {
        logic                    we;
        logic [RegAddrWidth-1:0] addr;
        logic [RegDataWidth-1:0] wdata;
    } reg_req_t;

    // Mask of implemented source bits within the 64-bit register view.
    function automatic logic [MaxSrc-1:0] impl_mask(input int unsigned n);
        if (n >= MaxSrc) begin
            return '1;
        end
        return (64'(1) << n) - 64'(1);
    endfunction

endpackage

// File: rtl/intr_claim_gateway.sv
// Per-source gateway: latches one pending event per claim/complete cycle.
// A claim moves the source into service; complete releases it for re-latching.
module intr_claim_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else if (claim) begin
            pending    <= 1'b0;
            in_service <= 1'b1;
        end else begin
            // In-service blocks new events until the complete has landed.
            if (src && !pending && !in_service) begin
                pending <= 1'b1;
            end
            if (complete) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/intr_claim_ctrl.sv
// Interrupt claim controller: per-source gateways, enables, fixed-priority
// claim (lowest index wins), completion port and a registered level IRQ.
module intr_claim_ctrl
    import intr_claim_ctrl_pkg::*;
#(
    parameter int unsigned NumSrc  = NumIrqSrc,
    parameter int unsigned IdWidth = IrqIdWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumSrc-1:0]       intr_src_i,
    input  logic                    reg_req_i,
    input  logic                    reg_we_i,
    input  logic [RegAddrWidth-1:0] reg_addr_i,
    input  logic [RegDataWidth-1:0] reg_wdata_i,
    output logic [RegDataWidth-1:0] reg_rdata_o,
    output logic                    reg_rvalid_o,
    output logic                    irq_o
);

    localparam logic [MaxSrc-1:0] ImplMask = impl_mask(NumSrc);

    reg_req_t                req;
    logic [MaxSrc-1:0]       enable;
    logic [MaxSrc-1:0]       pending_ext;
    logic [NumSrc-1:0]       pending;
    logic [NumSrc-1:0]       in_service;
    logic [NumSrc-1:0]       claimable;
    logic [NumSrc-1:0]       claim_sel;
    logic [NumSrc-1:0]       complete_sel;
    logic                    win_valid;
    logic [IdWidth-1:0]      win_idx;
    logic [IdWidth-1:0]      win_id;
    logic [IdWidth-1:0]      cmp_id;
    logic                    claim_rd;
    logic                    claim_fire;
    logic                    complete_wr;
    logic [RegDataWidth-1:0] rdata_c;

    assign req = '{we: reg_we_i, addr: reg_addr_i, wdata: reg_wdata_i};

    assign claimable   = pending & enable[NumSrc-1:0];
    assign pending_ext = MaxSrc'(pending);

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                win_valid = 1'b1;
                win_idx   = IdWidth'(i);
            end
        end
    end

    assign win_id = win_idx + IdWidth'(1);

    assign claim_rd    = reg_req_i && !req.we && (req.addr == IntrClaimOffset);
    assign claim_fire  = claim_rd && win_valid;
    assign complete_wr = reg_req_i && req.we && (req.addr == IntrClaimOffset);
    assign cmp_id      = req.wdata[IdWidth-1:0];

    for (genvar g = 0; g < NumSrc; g++) begin : g_src
        assign claim_sel[g]    = claim_fire && (win_idx == IdWidth'(g));
        assign complete_sel[g] = complete_wr && (cmp_id == IdWidth'(g + 1));

        intr_claim_gateway u_gateway (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .src        (intr_src_i[g]),
            .claim      (claim_sel[g]),
            .complete   (complete_sel[g]),
            .pending    (pending[g]),
            .in_service (in_service[g])
        );
    end

    // Read mux; writes return zero data alongside their response strobe.
    always_comb begin
        rdata_c = '0;
        if (!req.we) begin
            unique case (req.addr)
                IntrEnable0Offset:  rdata_c = enable[31:0];
                IntrEnable1Offset:  rdata_c = enable[63:32];
                IntrPending0Offset: rdata_c = pending_ext[31:0];
                IntrPending1Offset: rdata_c = pending_ext[63:32];
                IntrClaimOffset:    rdata_c = win_valid ? RegDataWidth'(win_id) : '0;
                default:            rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable <= '0;
        end else if (reg_req_i && req.we) begin
            if (req.addr == IntrEnable0Offset) begin
                enable[31:0] <= req.wdata & ImplMask[31:0];
            end else if (req.addr == IntrEnable1Offset) begin
                enable[63:32] <= req.wdata & ImplMask[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
            irq_o        <= 1'b0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= reg_req_i ? rdata_c : '0;
            irq_o        <= |claimable;
        end
    end

    // in_service only matters inside the gateways; kept visible for debug probes.
    logic unused_in_service;
    assign unused_in_service = ^in_service;

endmodule

// File: tb/tb_intr_claim_ctrl.sv
// Directed table-driven bench for intr_claim_ctrl with a hand-written
// reset-during-access sequence.
module tb_intr_claim_ctrl;

    localparam int unsigned NSRC = 46;
    localparam int unsigned IDW  = 7;

    localparam logic [63:0] S4  = 64'h0000_0000_0000_0010;
    localparam logic [63:0] S5  = 64'h0000_0000_0000_0020;
    localparam logic [63:0] S40 = 64'h0000_0100_0000_0000;

    typedef struct {
        logic [63:0] src;
        logic        req;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] intr_src = '0;
    logic            reg_req = 1'b0;
    logic            reg_we = 1'b0;
    logic [2:0]      reg_addr = '0;
    logic [31:0]     reg_wdata = '0;
    logic [31:0]     reg_rdata;
    logic            reg_rvalid;
    logic            irq;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    intr_claim_ctrl #(.NumSrc(NSRC), .IdWidth(IDW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .intr_src_i   (intr_src),
        .reg_req_i    (reg_req),
        .reg_we_i     (reg_we),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_rdata_o  (reg_rdata),
        .reg_rvalid_o (reg_rvalid),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    function automatic void add(logic [63:0] src, logic req, logic we, logic [2:0] addr,
                                logic [31:0] wdata, logic chk, logic [31:0] exp, logic ei);
        vec_t v;
        v.src = src; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.chk_data = chk; v.exp_rdata = exp; v.exp_irq = ei;
        vq.push_back(v);
    endfunction

    function automatic void rd(logic [63:0] src, logic [2:0] addr, logic [31:0] exp, logic ei);
        add(src, 1'b1, 1'b0, addr, 32'h0, 1'b1, exp, ei);
    endfunction

    function automatic void wr(logic [63:0] src, logic [2:0] addr, logic [31:0] data, logic ei);
        add(src, 1'b1, 1'b1, addr, data, 1'b0, 32'h0, ei);
    endfunction

    function automatic void idl(logic [63:0] src, logic ei);
        add(src, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, ei);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle, then check after the rising edge.
    task automatic run_vec(input int k);
        vec_t v;
        v = vq[k];
        intr_src  = v.src[NSRC-1:0];
        reg_req   = v.req;
        reg_we    = v.we;
        reg_addr  = v.addr;
        reg_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d rvalid", k), 32'(reg_rvalid), 32'(v.req));
        if (v.chk_data) begin
            check($sformatf("v%0d rdata", k), reg_rdata, v.exp_rdata);
        end
        check($sformatf("v%0d irq", k), 32'(irq), 32'(v.exp_irq));
    endtask

    initial begin
        int na;
        repeat (2) @(negedge clk);
        check("reset rvalid", 32'(reg_rvalid), 32'h0);
        check("reset rdata", reg_rdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // All offsets read zero; unimplemented enable bits stay zero.
        for (int a = 0; a < 8; a++) rd(64'h0, 3'(a), 32'h0, 1'b0);
        wr(64'h0, 3'd1, 32'hFFFF_FFFF, 1'b0);
        rd(64'h0, 3'd1, 32'h0000_3FFF, 1'b0);
        wr(64'h0, 3'd1, 32'h0, 1'b0);
        rd(64'h0, 3'd1, 32'h0, 1'b0);
        // Two-source pulse, priority order, irq drop.
        wr(64'h0, 3'd0, 32'h30, 1'b0);
        rd(64'h0, 3'd0, 32'h30, 1'b0);
        idl(S4 | S5, 1'b0);
        idl(64'h0, 1'b1);
        rd(64'h0, 3'd4, 32'd5, 1'b1);
        rd(64'h0, 3'd4, 32'd6, 1'b1);
        rd(64'h0, 3'd4, 32'd0, 1'b0);
        rd(64'h0, 3'd2, 32'h0, 1'b0);
        wr(64'h0, 3'd4, 32'd5, 1'b0);
        wr(64'h0, 3'd4, 32'd6, 1'b0);
        // Held source: one event per claim/complete cycle.
        idl(S4, 1'b0);
        rd(S4, 3'd4, 32'd5, 1'b1);
        rd(S4, 3'd2, 32'h0, 1'b0);
        rd(S4, 3'd4, 32'd0, 1'b0);
        wr(S4, 3'd4, 32'd5, 1'b0);
        rd(S4, 3'd2, 32'h0, 1'b0);
        rd(S4, 3'd2, 32'h10, 1'b1);
        rd(64'h0, 3'd4, 32'd5, 1'b1);
        idl(64'h0, 1'b0);
        wr(64'h0, 3'd4, 32'd5, 1'b0);
        // Disabled source latches pending, enabling later raises irq.
        idl(S40, 1'b0);
        rd(64'h0, 3'd3, 32'h100, 1'b0);
        wr(64'h0, 3'd1, 32'h100, 1'b0);
        idl(64'h0, 1'b1);
        rd(64'h0, 3'd4, 32'd41, 1'b1);
        idl(64'h0, 1'b0);
        // Invalid completes are ignored; upper data bits are ignored.
        idl(S4, 1'b0);
        wr(64'h0, 3'd4, 32'd0, 1'b1);
        wr(64'h0, 3'd4, 32'd47, 1'b1);
        wr(64'h0, 3'd4, 32'd6, 1'b1);
        wr(64'h0, 3'd4, 32'h100, 1'b1);
        rd(64'h0, 3'd2, 32'h10, 1'b1);
        rd(64'h0, 3'd3, 32'h0, 1'b1);
        rd(64'h0, 3'd4, 32'd5, 1'b1);
        rd(64'h0, 3'd2, 32'h0, 1'b0);
        wr(64'h0, 3'd4, 32'hA9, 1'b0);
        idl(S40, 1'b0);
        rd(64'h0, 3'd3, 32'h100, 1'b1);
        rd(64'h0, 3'd4, 32'd41, 1'b1);
        wr(64'h0, 3'd4, 32'd41, 1'b0);
        wr(64'h0, 3'd4, 32'd5, 1'b0);
        na = vq.size();

        for (int k = 0; k < na; k++) run_vec(k);

        // Reset asserted in the middle of a read with sources held high.
        intr_src = NSRC'(S4 | S40);
        reg_req  = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset irq", 32'(irq), 32'h1);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 3'd0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 check("reset-mid rvalid at edge", 32'(reg_rvalid), 32'h0);
        @(negedge clk);
        check("reset-mid rvalid", 32'(reg_rvalid), 32'h0);
        check("reset-mid irq", 32'(irq), 32'h0);
        reg_req = 1'b0;
        rst_n   = 1'b1;

        rd(S4 | S40, 3'd0, 32'h0, 1'b0);
        rd(S4 | S40, 3'd1, 32'h0, 1'b0);
        rd(S4 | S40, 3'd2, 32'h10, 1'b0);
        rd(S4 | S40, 3'd3, 32'h100, 1'b0);
        rd(S4 | S40, 3'd4, 32'h0, 1'b0);
        idl(64'h0, 1'b0);
        for (int k = na; k < vq.size(); k++) run_vec(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
